// File: rtl/count_uart_pkg.sv
// count_uart_pkg
// Shared types and helpers for the counter UART transmitter.
//   tx_state_e : line FSM states (IDLE, START, DATA, STOP)
//   baud_div() : clocks per UART bit, integer-truncated
//   FRAME_BITS : start + 8 data + stop
package count_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int FRAME_BITS = 10;

    function automatic int baud_div(int clk_hz, int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/count_uart_fifo.sv
// count_uart_fifo
// Small synchronous FIFO that decouples the byte producer from the UART line.
// Ports:
//   clk_12m : clock, all logic on posedge
//   rst     : synchronous reset, active-high; empties the FIFO
//   push    : write wdata this cycle (ignored when full)
//   pop     : drop the head entry this cycle (ignored when empty)
//   wdata   : entry to write
//   rdata   : current head entry, combinational
//   full    : DEPTH entries stored
//   empty   : no entries stored
module count_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_12m,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("count_uart_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_12m) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk_12m) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_when_full : assert property (@(posedge clk_12m) disable iff (rst) !(push && full));
    a_no_pop_when_empty : assert property (@(posedge clk_12m) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/count_uart_tx.sv
// count_uart_tx
// Serialises bytes from the counter onto a UART line, 8N1, LSB first.
// Ports:
//   clk_12m  : 12 MHz system clock, all logic on posedge
//   rst      : synchronous reset, active-high; abandons any frame in flight
//   in_data  : byte to send
//   in_valid : in_data is valid
//   in_ready : a byte can be accepted this cycle (FIFO not full)
//   tx       : UART line, idle high, registered
//   busy     : a frame is in progress or bytes are queued
module count_uart_tx #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_12m,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    import count_uart_pkg::*;

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
    // Index of the final data bit: frame minus start and stop, minus one.
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    if (DIV < 2) begin : g_bad_div
        $error("count_uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_e     state;
    tx_state_e     state_d;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_d;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_d;
    logic          tx_d;
    logic          bit_end;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign bit_end   = (baud_cnt == LAST_TICK);
    assign bit_nxt   = bit_idx + 3'd1;

    count_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_12m (clk_12m),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (in_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_idx   <= bit_d;
            shift_reg <= shift_d;
            tx        <= tx_d;
        end
    end

    // tx_d is the line level of the bit that starts at the coming edge, so
    // tx changes on the same edge as the state and never glitches.
    always_comb begin
        state_d  = state;
        baud_d   = baud_cnt;
        bit_d    = bit_idx;
        shift_d  = shift_reg;
        tx_d     = tx;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_reg[0];
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shift_reg[bit_nxt];
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // A queued byte starts straight after the stop bit.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    a_tx_high_in_idle : assert property (@(posedge clk_12m) disable iff (rst) (state == IDLE) |-> tx);

endmodule
